// File: rtl/game_seq_pkg.sv
// Shared types for the game play sequencer: commands, matrix-port select, FSM states.
// Also holds the score table used when GAME_SEQ_SCORE_EN is defined.
package game_seq_pkg;

  typedef enum logic [2:0] {
    eLEFT   = 3'd0,
    eRIGHT  = 3'd1,
    eROTATE = 3'd2,
    eDOWN   = 3'd3,
    eDROP   = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    eSEL_NONE  = 2'd0,
    eSEL_SPAWN = 2'd1,
    eSEL_MOVE  = 2'd2,
    eSEL_CHECK = 2'd3
  } mm_sel_e;

  typedef enum logic [3:0] {
    eINIT   = 4'd0,
    eSPAWN  = 4'd1,
    eWSPAWN = 4'd2,
    eREADY  = 4'd3,
    eMOVE   = 4'd4,
    eWMOVE  = 4'd5,
    eCHECK  = 4'd6,
    eWCHECK = 4'd7,
    eCAPT   = 4'd8,
    eOVER   = 4'd9
  } state_e;

  // Points per clear of 0..4 rows; anything above four rows earns the four-row value.
  localparam logic [4:0][3:0] score_table_lp = {4'd8, 4'd5, 4'd3, 4'd1, 4'd0};

  function automatic logic [3:0] score_of(input logic [2:0] rows);
    logic [3:0] pts;
    if (rows > 3'd4) begin
      pts = score_table_lp[4];
    end else begin
      pts = score_table_lp[rows];
    end
    return pts;
  endfunction

  function automatic mm_sel_e sel_of(input state_e st);
    mm_sel_e sel;
    case (st)
      eSPAWN, eWSPAWN:       sel = eSEL_SPAWN;
      eMOVE, eWMOVE:         sel = eSEL_MOVE;
      eCHECK, eWCHECK, eCAPT: sel = eSEL_CHECK;
      default:               sel = eSEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/game_seq_lines_acc.sv
// Saturating cleared-line accumulator, loaded once per piece lock.
// With GAME_SEQ_SCORE_EN defined it also keeps a saturating score.
module game_seq_lines_acc
  import game_seq_pkg::*;
#(
  parameter int lines_width_p = 16
`ifdef GAME_SEQ_SCORE_EN
  , parameter int score_width_p = 20
`endif
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic [2:0]               number_i,
`ifdef GAME_SEQ_SCORE_EN
  output logic [score_width_p-1:0] score_o,
`endif
  output logic [lines_width_p-1:0] lines_o
);

  localparam int lsum_w_lp = ((lines_width_p > 3) ? lines_width_p : 3) + 1;

  logic [lines_width_p-1:0] lines_r;
  logic [lines_width_p-1:0] lines_n_s;
  logic [lsum_w_lp-1:0]     lines_sum_s;
  logic [lsum_w_lp-1:0]     lines_max_s;

  // Next line count: add rows cleared, pin at all-ones instead of wrapping.
  always_comb begin
    lines_sum_s = lsum_w_lp'(lines_r) + lsum_w_lp'(number_i);
    lines_max_s = lsum_w_lp'({lines_width_p{1'b1}});
    if (lines_sum_s > lines_max_s) begin
      lines_n_s = {lines_width_p{1'b1}};
    end else begin
      lines_n_s = lines_sum_s[lines_width_p-1:0];
    end
  end

  // Line counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lines_r <= {lines_width_p{1'b0}};
    end else if (en_i) begin
      lines_r <= lines_n_s;
    end
  end

  assign lines_o = lines_r;

`ifdef GAME_SEQ_SCORE_EN
  localparam int ssum_w_lp = ((score_width_p > 4) ? score_width_p : 4) + 1;

  logic [score_width_p-1:0] score_r;
  logic [score_width_p-1:0] score_n_s;
  logic [ssum_w_lp-1:0]     score_sum_s;
  logic [ssum_w_lp-1:0]     score_max_s;

  // Next score: table lookup on rows cleared, saturating.
  always_comb begin
    score_sum_s = ssum_w_lp'(score_r) + ssum_w_lp'(score_of(number_i));
    score_max_s = ssum_w_lp'({score_width_p{1'b1}});
    if (score_sum_s > score_max_s) begin
      score_n_s = {score_width_p{1'b1}};
    end else begin
      score_n_s = score_sum_s[score_width_p-1:0];
    end
  end

  // Score register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      score_r <= {score_width_p{1'b0}};
    end else if (en_i) begin
      score_r <= score_n_s;
    end
  end

  assign score_o = score_r;
`endif

endmodule

// File: rtl/game_sequencer.sv
// Play controller: runs spawn, move and check executors one at a time and owns mm_sel_o,
// which steers the shared matrix-memory port. Optional score output via GAME_SEQ_SCORE_EN.
module game_sequencer
  import game_seq_pkg::*;
#(
  parameter int lines_width_p = 16
`ifdef GAME_SEQ_SCORE_EN
  , parameter int score_width_p = 20
`endif
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     tick_i,
  input  logic                     cmd_v_i,
  input  cmd_e                     cmd_i,
  output logic                     cmd_ready_o,
  output logic                     spawn_v_o,
  input  logic                     spawn_done_i,
  input  logic                     spawn_collide_i,
  output logic                     move_v_o,
  output cmd_e                     move_cmd_o,
  input  logic                     move_done_i,
  input  logic                     move_collide_i,
  output logic                     check_v_o,
  input  logic                     check_done_i,
  input  logic [2:0]               combine_number_i,
  output mm_sel_e                  mm_sel_o,
`ifdef GAME_SEQ_SCORE_EN
  output logic [score_width_p-1:0] score_o,
`endif
  output logic [lines_width_p-1:0] lines_o,
  output logic                     game_over_o
);

  state_e  state_r, state_n_s;
  logic    tick_pending_r, tick_pending_n_s;
  logic    drop_r, drop_n_s;
  cmd_e    move_cmd_r, move_cmd_n_s;
  logic    cmd_ready_r, spawn_v_r, move_v_r, check_v_r, game_over_r;
  mm_sel_e mm_sel_r;
  logic    capt_en_s;

  // Next-state, pending-tick and drop-mode logic.
  always_comb begin
    state_n_s        = state_r;
    tick_pending_n_s = tick_pending_r | tick_i;
    drop_n_s         = drop_r;
    move_cmd_n_s     = move_cmd_r;
    case (state_r)
      eINIT:   state_n_s = eSPAWN;
      eSPAWN:  state_n_s = eWSPAWN;
      eWSPAWN: begin
        if (spawn_done_i) begin
          state_n_s = spawn_collide_i ? eOVER : eREADY;
        end else begin
          state_n_s = eWSPAWN;
        end
      end
      eREADY: begin
        if (drop_r) begin
          move_cmd_n_s = eDOWN;
          state_n_s    = eMOVE;
        end else if (tick_pending_r) begin
          move_cmd_n_s     = eDOWN;
          tick_pending_n_s = 1'b0;
          state_n_s        = eMOVE;
        end else if (cmd_v_i && cmd_ready_r) begin
          if (cmd_i == eDROP) begin
            drop_n_s     = 1'b1;
            move_cmd_n_s = eDOWN;
          end else begin
            move_cmd_n_s = cmd_i;
          end
          state_n_s = eMOVE;
        end else begin
          state_n_s = eREADY;
        end
      end
      eMOVE:   state_n_s = eWMOVE;
      eWMOVE: begin
        if (move_done_i) begin
          // A blocked downward step locks the piece; any other blocked move is a no-op.
          if (move_collide_i && (move_cmd_r == eDOWN)) begin
            drop_n_s  = 1'b0;
            state_n_s = eCHECK;
          end else begin
            state_n_s = eREADY;
          end
        end else begin
          state_n_s = eWMOVE;
        end
      end
      eCHECK:  state_n_s = eWCHECK;
      eWCHECK: begin
        if (check_done_i) begin
          state_n_s = eCAPT;
        end else begin
          state_n_s = eWCHECK;
        end
      end
      eCAPT:   state_n_s = eSPAWN;
      eOVER: begin
        state_n_s        = eOVER;
        tick_pending_n_s = tick_pending_r;
      end
      default: state_n_s = eINIT;
    endcase
  end

  // State and output registers; outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r        <= eINIT;
      tick_pending_r <= 1'b0;
      drop_r         <= 1'b0;
      move_cmd_r     <= eLEFT;
      cmd_ready_r    <= 1'b0;
      spawn_v_r      <= 1'b0;
      move_v_r       <= 1'b0;
      check_v_r      <= 1'b0;
      game_over_r    <= 1'b0;
      mm_sel_r       <= eSEL_NONE;
    end else begin
      state_r        <= state_n_s;
      tick_pending_r <= tick_pending_n_s;
      drop_r         <= drop_n_s;
      move_cmd_r     <= move_cmd_n_s;
      cmd_ready_r    <= (state_n_s == eREADY) && !tick_pending_n_s && !drop_n_s;
      spawn_v_r      <= (state_n_s == eSPAWN);
      move_v_r       <= (state_n_s == eMOVE);
      check_v_r      <= (state_n_s == eCHECK);
      game_over_r    <= (state_n_s == eOVER);
      mm_sel_r       <= sel_of(state_n_s);
    end
  end

  assign capt_en_s = (state_r == eCAPT);

  game_seq_lines_acc #(
    .lines_width_p(lines_width_p)
`ifdef GAME_SEQ_SCORE_EN
    , .score_width_p(score_width_p)
`endif
  ) u_lines_acc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (capt_en_s),
    .number_i(combine_number_i),
`ifdef GAME_SEQ_SCORE_EN
    .score_o (score_o),
`endif
    .lines_o (lines_o)
  );

  assign cmd_ready_o = cmd_ready_r;
  assign spawn_v_o   = spawn_v_r;
  assign move_v_o    = move_v_r;
  assign move_cmd_o  = move_cmd_r;
  assign check_v_o   = check_v_r;
  assign mm_sel_o    = mm_sel_r;
  assign game_over_o = game_over_r;

endmodule
